// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared constants, FSM state type and helpers for the SPI
//               slave and its synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Default frame width in bits
    localparam int c_DATA_W_DEFAULT = 8;

    // Slowest supported clk/sclk ratio; sclk must not run faster than clk/8
    localparam int c_MIN_CLK_SCLK_RATIO = 8;

    // Slave FSM states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_t;

    // Width of a counter that must hold values 0..w-1 (at least one bit)
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync
// Description : Single-bit multi-flop synchronizer with a configurable
//               reset level, used to bring SPI pins into the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the pin value through the flop chain; reset to the pin's idle level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_chain[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign q = r_chain[SYNC_STAGES-1];

endmodule : spi_sync
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave
// Description : SPI mode-0, MSB-first slave with oversampled pin inputs,
//               TX shadow register with underrun detection, back-to-back
//               frame support and a one-cycle rx_valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = c_DATA_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              tx_underrun
);

    localparam int                    c_CNT_W     = cnt_width(DATA_W);
    localparam int                    c_FLUSH_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [c_CNT_W-1:0]    c_LAST_BIT  = c_CNT_W'(DATA_W - 1);
    localparam logic [c_FLUSH_W-1:0]  c_FLUSH_CYC = c_FLUSH_W'(SYNC_STAGES + 1);

    // Synchronized pins and their one-cycle delayed copies
    logic w_sclk_s, w_ss_s, w_mosi_s;
    logic r_sclk_d, r_ss_d;
    logic [c_FLUSH_W-1:0] r_flush_cnt;

    // Edge strobes and frame events
    logic w_sync_ready;
    logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
    logic w_frame_start, w_frame_end;
    logic w_shift_active, w_rx_sample, w_tx_advance, w_tx_reload;
    logic [DATA_W-1:0] w_load_value, w_rx_next;

    // FSM
    spi_state_t r_state, w_state_next;

    // Datapath registers
    logic [DATA_W-1:0]  r_shadow, r_tx_shift, r_rx_shift, r_rx_data;
    logic               r_fresh, r_pend, r_pend_uflow, r_tx_underrun, r_rx_valid;
    logic [c_CNT_W-1:0] r_bit_cnt;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(sclk), .q(w_sclk_s)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset(reset), .d(ss), .q(w_ss_s)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(mosi), .q(w_mosi_s)
    );

    // Delay the synchronized pins for edge detection; count out the flush
    // window after reset so a pin still held low cannot look like an ss fall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
            r_flush_cnt <= '0;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_ss_d   <= w_ss_s;
            if (r_flush_cnt != c_FLUSH_CYC) begin
                r_flush_cnt <= r_flush_cnt + c_FLUSH_W'(1);
            end
        end
    end

    assign w_sync_ready = (r_flush_cnt == c_FLUSH_CYC);
    assign w_sclk_rise  =  w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall  = ~w_sclk_s &  r_sclk_d;
    assign w_ss_fall    = ~w_ss_s   &  r_ss_d & w_sync_ready;
    assign w_ss_rise    =  w_ss_s   & ~r_ss_d;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and frame start/end events
    always_comb begin
        w_state_next  = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_state_next  = ST_SHIFT;
                    w_frame_start = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_ss_rise) begin
                    w_state_next = ST_IDLE;
                    w_frame_end  = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // A falling edge seen with the counter back at zero means a full frame
    // has just completed while ss stays low: reload for the next frame
    assign w_shift_active = (r_state == ST_SHIFT) & ~w_ss_rise;
    assign w_rx_sample    = w_shift_active & w_sclk_rise;
    assign w_tx_advance   = w_shift_active & w_sclk_fall;
    assign w_tx_reload    = w_tx_advance & (r_bit_cnt == '0);
    assign w_load_value   = tx_load ? tx_data : r_shadow;
    assign w_rx_next      = {r_rx_shift[DATA_W-2:0], w_mosi_s};

    // Shadow register, fresh flag and underrun reporting. A back-to-back
    // reload defers its underrun pulse to the first sampling edge of the new
    // frame, so a frame that simply ends never reports a spurious underrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow      <= '0;
            r_fresh       <= 1'b0;
            r_pend        <= 1'b0;
            r_pend_uflow  <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_tx_underrun <= 1'b0;
            if (w_frame_start) begin
                r_tx_underrun <= ~r_fresh & ~tx_load;
            end
            if (w_rx_sample && r_pend) begin
                r_tx_underrun <= r_pend_uflow;
                r_pend        <= 1'b0;
            end
            if (w_tx_reload) begin
                r_pend       <= 1'b1;
                r_pend_uflow <= ~r_fresh & ~tx_load;
            end
            if (w_frame_end) begin
                r_pend <= 1'b0;
            end
            if (tx_load) begin
                r_shadow <= tx_data;
                r_fresh  <= ~(w_frame_start | w_tx_reload);
            end else if (w_frame_start || w_tx_reload) begin
                r_fresh <= 1'b0;
            end
        end
    end

    // TX shift register: load at frame start or reload, shift on falling edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_shift <= '0;
        end else if (w_frame_start || w_tx_reload) begin
            r_tx_shift <= w_load_value;
        end else if (w_tx_advance) begin
            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
        end
    end

    // RX shift register, bit counter and completed-byte output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_bit_cnt  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_frame_start || w_frame_end) begin
                r_bit_cnt <= '0;
            end else if (w_rx_sample) begin
                r_rx_shift <= w_rx_next;
                if (r_bit_cnt == c_LAST_BIT) begin
                    r_bit_cnt  <= '0;
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    assign busy        = (r_state == ST_SHIFT);
    assign miso        = (r_state == ST_SHIFT) & r_tx_shift[DATA_W-1];
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_tx_underrun;

endmodule : spi_slave
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave
// Description : Self-checking bench for spi_slave: a mode-0 master model
//               drives frames at clk/8 while a scoreboard matches received
//               bytes against expectations queued at stimulus time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;

    logic              clk;
    logic              reset;
    logic              sclk;
    logic              ss;
    logic              mosi;
    logic              miso;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              tx_underrun;

    int errors = 0;
    int checks = 0;
    int rx_cnt = 0;
    int ufl_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    logic [7:0] model_rx = 8'h00;

    spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .tx_data(tx_data), .tx_load(tx_load),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .tx_underrun(tx_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every rx_valid pulse must match the oldest expected byte
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: rx_valid with rx_data=%h, none expected", rx_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (rx_data !== exp_b) begin
                    errors++;
                    $display("FAIL rx_byte: got %h expected %h", rx_data, exp_b);
                end
            end
        end
        if (tx_underrun) ufl_cnt++;
    end

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] v);
        @(negedge clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        ss = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic end_frame();
        half();
        ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Mode-0 master: mosi set while sclk low, miso captured at the rising edge
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            half();
            sclk = 1'b1;
            rx[i] = miso;
            half();
            sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
        tx_load = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        checks++; if (miso !== 1'b0)        begin errors++; $display("FAIL rst_miso: got %b expected 0", miso); end
        checks++; if (rx_valid !== 1'b0)    begin errors++; $display("FAIL rst_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b expected 0", tx_underrun); end
        checks++; if (rx_data !== 8'h00)    begin errors++; $display("FAIL rst_rx_data: got %h expected 00", rx_data); end
        reset = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_basic();
        int r0, u0;
        logic [7:0] got;
        load(8'h3C);
        r0 = rx_cnt; u0 = ufl_cnt;
        start_frame();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        exp_q.push_back(8'hA5); model_rx = 8'hA5;
        xfer(8'hA5, 8, got);
        end_frame();
        checks++; if (got !== 8'h3C) begin errors++; $display("FAIL basic_miso: got %h expected 3c", got); end
        checks++; if (rx_cnt - r0 != 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", rx_cnt - r0); end
        checks++; if (ufl_cnt - u0 != 0) begin errors++; $display("FAIL basic_underrun: got %0d expected 0", ufl_cnt - u0); end
        checks++; if (rx_data !== model_rx) begin errors++; $display("FAIL basic_rx_data: got %h expected %h", rx_data, model_rx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_underrun();
        int r0, u0;
        logic [7:0] got;
        r0 = rx_cnt; u0 = ufl_cnt;
        start_frame();
        exp_q.push_back(8'h96); model_rx = 8'h96;
        xfer(8'h96, 8, got);
        end_frame();
        checks++; if (got !== 8'h3C) begin errors++; $display("FAIL ufl_miso: got %h expected 3c", got); end
        checks++; if (ufl_cnt - u0 != 1) begin errors++; $display("FAIL ufl_pulses: got %0d expected 1", ufl_cnt - u0); end
        checks++; if (rx_cnt - r0 != 1) begin errors++; $display("FAIL ufl_rx_pulses: got %0d expected 1", rx_cnt - r0); end
    endtask

    task automatic test_back_to_back();
        int r0, u0;
        logic [7:0] g1, g2;
        load(8'h11);
        r0 = rx_cnt; u0 = ufl_cnt;
        start_frame();
        load(8'h22);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80); model_rx = 8'h80;
        xfer(8'h01, 8, g1);
        xfer(8'h80, 8, g2);
        end_frame();
        checks++; if (g1 !== 8'h11) begin errors++; $display("FAIL b2b_miso0: got %h expected 11", g1); end
        checks++; if (g2 !== 8'h22) begin errors++; $display("FAIL b2b_miso1: got %h expected 22", g2); end
        checks++; if (rx_cnt - r0 != 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", rx_cnt - r0); end
        checks++; if (ufl_cnt - u0 != 0) begin errors++; $display("FAIL b2b_underrun: got %0d expected 0", ufl_cnt - u0); end
        checks++; if (rx_data !== model_rx) begin errors++; $display("FAIL b2b_rx_data: got %h expected %h", rx_data, model_rx); end
    endtask

    task automatic test_abort();
        int r0, u0;
        bit dropped;
        logic [7:0] got;
        load(8'hE7);
        r0 = rx_cnt;
        start_frame();
        xfer(8'hFF, 5, got);
        half();
        ss = 1'b1;
        dropped = 1'b0;
        for (int i = 1; i <= SYNC_STAGES + 2; i++) begin
            @(negedge clk);
            if (!busy) begin
                dropped = 1'b1;
                break;
            end
        end
        checks++; if (!dropped) begin errors++; $display("FAIL abort_busy: busy=%b after %0d cycles expected 0", busy, SYNC_STAGES + 2); end
        repeat (8) @(negedge clk);
        checks++; if (rx_cnt - r0 != 0) begin errors++; $display("FAIL abort_pulses: got %0d expected 0", rx_cnt - r0); end
        checks++; if (rx_data !== model_rx) begin errors++; $display("FAIL abort_rx_data: got %h expected %h", rx_data, model_rx); end
        load(8'hB4);
        u0 = ufl_cnt;
        start_frame();
        exp_q.push_back(8'h5A); model_rx = 8'h5A;
        xfer(8'h5A, 8, got);
        end_frame();
        checks++; if (got !== 8'hB4) begin errors++; $display("FAIL abort_next_miso: got %h expected b4", got); end
        checks++; if (ufl_cnt - u0 != 0) begin errors++; $display("FAIL abort_next_underrun: got %0d expected 0", ufl_cnt - u0); end
        checks++; if (rx_data !== model_rx) begin errors++; $display("FAIL abort_next_rx: got %h expected %h", rx_data, model_rx); end
    endtask

    task automatic test_reset_midframe();
        int r0;
        logic [7:0] got;
        load(8'h77);
        r0 = rx_cnt;
        start_frame();
        xfer(8'hAA, 4, got);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (miso !== 1'b0)        begin errors++; $display("FAIL mrst_miso: got %b expected 0", miso); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL mrst_busy: got %b expected 0", busy); end
        checks++; if (rx_valid !== 1'b0)    begin errors++; $display("FAIL mrst_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL mrst_underrun: got %b expected 0", tx_underrun); end
        checks++; if (rx_data !== 8'h00)    begin errors++; $display("FAIL mrst_rx_data: got %h expected 00", rx_data); end
        model_rx = 8'h00;
        ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (rx_cnt - r0 != 0) begin errors++; $display("FAIL mrst_pulses: got %0d expected 0", rx_cnt - r0); end
        load(8'h5E);
        start_frame();
        exp_q.push_back(8'hC3); model_rx = 8'hC3;
        xfer(8'hC3, 8, got);
        end_frame();
        checks++; if (got !== 8'h5E) begin errors++; $display("FAIL mrst_next_miso: got %h expected 5e", got); end
        checks++; if (rx_data !== model_rx) begin errors++; $display("FAIL mrst_next_rx: got %h expected %h", rx_data, model_rx); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_back_to_back();
        test_abort();
        test_reset_midframe();
        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected bytes never received, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_spi_slave
`default_nettype wire

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the frame width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth on sclk, ss and mosi.
REQ-003 clk  input  1  system clock; all logic SHALL be synchronous to its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 sclk  input  1  SPI clock from the master, asynchronous to clk.
REQ-006 ss  input  1  slave select, active low, asynchronous to clk.
REQ-007 mosi  input  1  serial data from the master.
REQ-008 miso  output  1  serial data to the master.
REQ-009 tx_data  input  DATA_W  next byte to return to the master.
REQ-010 tx_load  input  1  one-cycle strobe that writes tx_data into the TX shadow register.
REQ-011 rx_data  output  DATA_W  last complete byte received.
REQ-012 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-013 busy  output  1  high while the FSM is in the SHIFT state.
REQ-014 tx_underrun  output  1  one-cycle pulse when a frame starts with no fresh tx_load.

Function
REQ-015 SPI mode 0, MSB first: mosi SHALL be sampled on the synchronized sclk rising edge, and miso SHALL change on the synchronized sclk falling edge.
REQ-016 sclk, ss and mosi SHALL each pass through SYNC_STAGES flops; edges SHALL be detected from the last stage against one further delayed copy.
REQ-017 Supported sclk frequency SHALL be at most clk/8; behaviour above that rate is undefined.
REQ-018 FSM states: IDLE and SHIFT.
- IDLE->SHIFT on a synchronized ss falling edge.
- SHIFT->IDLE on a synchronized ss rising edge.
REQ-019 On IDLE->SHIFT, the TX shift register SHALL load the shadow, miso SHALL present bit DATA_W-1 that same cycle, and the bit counter SHALL clear.
REQ-020 Each sampling edge in SHIFT SHALL shift mosi into the LSB of the RX shift register and increment the bit counter.
REQ-021 On the DATA_W-th sampling edge, rx_data SHALL take the assembled byte and rx_valid SHALL pulse in the following clk cycle. Latency from the sclk pin edge SHALL be at most SYNC_STAGES+2 clk cycles.
REQ-022 The bit counter SHALL wrap to 0 after DATA_W bits; with ss still low, the next falling edge SHALL reload the TX shift register from the shadow (back-to-back frames).
REQ-023 A frame load SHALL clear the "fresh" flag. If the flag was already clear at load time, tx_underrun SHALL pulse and the stale shadow SHALL be retransmitted.
REQ-024 tx_load SHALL be accepted in any state: it sets the fresh flag and overwrites the shadow. If tx_load coincides with a frame load, the new tx_data SHALL be loaded directly and no underrun SHALL be flagged.
REQ-025 An ss rising edge before DATA_W bits SHALL discard the partial byte: no rx_valid, rx_data unchanged, counter cleared.
REQ-026 miso SHALL be driven 0 while in IDLE (no tristate).
REQ-027 rx_valid SHALL pulse regardless of whether the previous byte was consumed; the consumer owns overflow.

Reset
REQ-028 Reset SHALL force:
- FSM to IDLE;
- miso, rx_valid, busy, tx_underrun, the bit counter and rx_data to 0;
- the TX shadow to 0 with the fresh flag clear;
- all synchronizer flops to the idle level (sclk 0, ss 1, mosi 0).
REQ-029 Reset mid-frame SHALL abandon the frame with no rx_valid. After release, a new frame SHALL begin only on a subsequent ss falling edge.

Structure
REQ-030 A shared package spi_pkg SHALL hold the DATA_W default, the FSM state enumeration and the minimum clk/sclk ratio constant (8).
REQ-031 A sub-module spi_sync (parameterized SYNC_STAGES flop chain with reset value parameter) SHALL be instantiated once each for sclk, ss and mosi.

Verification
REQ-032 tx_load 0x3C, then the master sends 0xA5 at clk/8 -> rx_data=0xA5, exactly one rx_valid pulse, miso bits 0,0,1,1,1,1,0,0, tx_underrun stays 0.
REQ-033 Back-to-back 0x01 then 0x80 with ss held low, tx_load 0x11 then 0x22 before each frame -> two rx_valid pulses (0x01, 0x80), miso returns 0x11 then 0x22.
REQ-034 ss raised after 5 bits of 0xFF -> no rx_valid, rx_data keeps its prior value, busy drops within SYNC_STAGES+2 cycles, and the next full frame of 0x5A is received correctly.
REQ-035 Second frame with no tx_load after the first (shadow 0x3C) -> tx_underrun pulses once at frame start and miso repeats 0x3C.
REQ-036 reset asserted after bit 4 of a frame -> all outputs 0 immediately, no rx_valid. A following ss cycle with 0xC3 -> rx_data=0xC3.
